// File: rtl/barrett_reduction_pipe.sv
// barrett_reduction_pipe
//   Three-stage, multi-lane Barrett reduction of 2*REG_SIZE-bit operands
//   modulo PRIME, with valid/ready flow control and a pass-through tag.
//
// Ports
//   clk, reset_n   clock, asynchronous active-low reset
//   zeroize        synchronous clear of every pipeline register
//   in_valid/ready input handshake; in_x packs LANES operands, lane i at
//                  [i*2*REG_SIZE +: 2*REG_SIZE]; in_tag rides with the beat
//   out_valid/ready output handshake
//   out_r          x mod PRIME per lane (always exact)
//   out_q          floor(x / PRIME) per lane, low REG_SIZE bits
//   out_ovf        per-lane flag: quotient did not fit in REG_SIZE bits
//   out_tag        tag of the beat currently on the output
module barrett_reduction_pipe #(
    parameter int unsigned PRIME    = 3329,
    parameter int unsigned REG_SIZE = $clog2(PRIME),
    parameter int unsigned LANES    = 4,
    parameter int unsigned TAG_W    = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          zeroize,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*2*REG_SIZE-1:0]   in_x,
    input  logic [TAG_W-1:0]              in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*REG_SIZE-1:0]     out_r,
    output logic [LANES*REG_SIZE-1:0]     out_q,
    output logic [LANES-1:0]              out_ovf,
    output logic [TAG_W-1:0]              out_tag
);

    localparam int unsigned K   = 2 * REG_SIZE;
    localparam int unsigned X_W = K;
    localparam int unsigned U_W = REG_SIZE + 1;
    localparam int unsigned P_W = 3 * REG_SIZE + 1;
    localparam int unsigned E_W = 2 * REG_SIZE + 1;
    localparam int unsigned Q_W = REG_SIZE + 2;
    localparam int unsigned C_W = 2 * REG_SIZE + 1;

    // M = floor(2^K / PRIME), evaluated at elaboration time.
    localparam logic [K:0]     ONE_K       = {1'b1, {K{1'b0}}};
    localparam logic [K:0]     PRIME_K     = (K + 1)'(PRIME);
    localparam logic [K:0]     M_FULL      = ONE_K / PRIME_K;
    localparam logic [U_W-1:0] M           = M_FULL[U_W-1:0];
    localparam logic [E_W-1:0] PRIME_E     = E_W'(PRIME);
    localparam logic [E_W-1:0] TWO_PRIME_E = PRIME_E << 1;

    // Final correction: the estimate is at most two multiples of PRIME high,
    // so two compares bring it into [0, PRIME). Returns {ovf, q, r}.
    function automatic logic [C_W-1:0] correct(input logic [U_W-1:0] u,
                                               input logic [E_W-1:0] e);
        logic [Q_W-1:0]      q_full;
        logic [REG_SIZE-1:0] r;
        if (e >= TWO_PRIME_E) begin
            r      = REG_SIZE'(e - TWO_PRIME_E);
            q_full = Q_W'(u) + Q_W'(2'd2);
        end else if (e >= PRIME_E) begin
            r      = REG_SIZE'(e - PRIME_E);
            q_full = Q_W'(u) + Q_W'(2'd1);
        end else begin
            r      = REG_SIZE'(e);
            q_full = Q_W'(u);
        end
        return {|q_full[Q_W-1:REG_SIZE], q_full[REG_SIZE-1:0], r};
    endfunction

    logic                 vld_p1, vld_p2, vld_p3;
    logic                 acc_p1, acc_p2, acc_p3;
    logic                 fire_in;

    logic [X_W-1:0]       x_p1   [LANES];
    logic [P_W-1:0]       p_p1   [LANES];
    logic [TAG_W-1:0]     tag_p1;
    logic [U_W-1:0]       u_p2   [LANES];
    logic [E_W-1:0]       e_p2   [LANES];
    logic [TAG_W-1:0]     tag_p2;
    logic [REG_SIZE-1:0]  r_p3   [LANES];
    logic [REG_SIZE-1:0]  q_p3   [LANES];
    logic [LANES-1:0]     ovf_p3;
    logic [TAG_W-1:0]     tag_p3;

    logic [P_W-1:0]       p_c    [LANES];
    logic [U_W-1:0]       u_c    [LANES];
    logic [E_W-1:0]       e_c    [LANES];
    logic [REG_SIZE-1:0]  r_c    [LANES];
    logic [REG_SIZE-1:0]  q_c    [LANES];
    logic [LANES-1:0]     ovf_c;

    // A stage accepts when it is empty or its contents move on this cycle,
    // so bubbles collapse even while the output is stalled.
    assign acc_p3   = !vld_p3 || out_ready;
    assign acc_p2   = !vld_p2 || acc_p3;
    assign acc_p1   = !vld_p1 || acc_p2;
    assign in_ready = acc_p1 && !zeroize;
    assign fire_in  = in_valid && in_ready;

    always_comb begin
        ovf_c = '0;
        for (int i = 0; i < LANES; i++) begin
            p_c[i] = P_W'(in_x[i*X_W +: X_W]) * P_W'(M);
            u_c[i] = U_W'(p_p1[i] >> K);
            // Wraps modulo 2^E_W, but the true value is in [0, 3*PRIME).
            e_c[i] = E_W'(x_p1[i]) - E_W'(u_c[i]) * PRIME_E;
            {ovf_c[i], q_c[i], r_c[i]} = correct(u_p2[i], e_p2[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else if (zeroize) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else begin
            if (acc_p1) vld_p1 <= in_valid;
            if (acc_p2) vld_p2 <= vld_p1;
            if (acc_p3) vld_p3 <= vld_p2;
        end
    end

    // ---- stage 1: capture operand and full-width x*M ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LANES; i++) begin
                x_p1[i] <= '0;
                p_p1[i] <= '0;
            end
            tag_p1 <= '0;
        end else if (zeroize) begin
            for (int i = 0; i < LANES; i++) begin
                x_p1[i] <= '0;
                p_p1[i] <= '0;
            end
            tag_p1 <= '0;
        end else if (fire_in) begin
            for (int i = 0; i < LANES; i++) begin
                x_p1[i] <= in_x[i*X_W +: X_W];
                p_p1[i] <= p_c[i];
            end
            tag_p1 <= in_tag;
        end
    end

    // ---- stage 2: quotient estimate and raw remainder ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LANES; i++) begin
                u_p2[i] <= '0;
                e_p2[i] <= '0;
            end
            tag_p2 <= '0;
        end else if (zeroize) begin
            for (int i = 0; i < LANES; i++) begin
                u_p2[i] <= '0;
                e_p2[i] <= '0;
            end
            tag_p2 <= '0;
        end else if (acc_p2 && vld_p1) begin
            for (int i = 0; i < LANES; i++) begin
                u_p2[i] <= u_c[i];
                e_p2[i] <= e_c[i];
            end
            tag_p2 <= tag_p1;
        end
    end

    // ---- stage 3: corrected remainder, quotient and overflow ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LANES; i++) begin
                r_p3[i] <= '0;
                q_p3[i] <= '0;
            end
            ovf_p3 <= '0;
            tag_p3 <= '0;
        end else if (zeroize) begin
            for (int i = 0; i < LANES; i++) begin
                r_p3[i] <= '0;
                q_p3[i] <= '0;
            end
            ovf_p3 <= '0;
            tag_p3 <= '0;
        end else if (acc_p3 && vld_p2) begin
            for (int i = 0; i < LANES; i++) begin
                r_p3[i] <= r_c[i];
                q_p3[i] <= q_c[i];
            end
            ovf_p3 <= ovf_c;
            tag_p3 <= tag_p2;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_out
        assign out_r[g*REG_SIZE +: REG_SIZE] = r_p3[g];
        assign out_q[g*REG_SIZE +: REG_SIZE] = q_p3[g];
    end

    assign out_valid = vld_p3;
    assign out_ovf   = ovf_p3;
    assign out_tag   = tag_p3;

endmodule

// File: tb/tb_barrett_reduction_pipe.sv
// tb_barrett_reduction_pipe
//   Self-checking bench for barrett_reduction_pipe. One instance uses
//   PRIME=3329 (REG_SIZE=12) for the flow-control scenarios, a second uses
//   PRIME=8380417 (REG_SIZE=23) in the random sweep. Expected results are
//   pushed into per-instance scoreboards on every accepted beat and popped
//   when the matching output handshake occurs.
module tb_barrett_reduction_pipe;

    localparam int P_A  = 3329;
    localparam int RS_A = 12;
    localparam int P_B  = 8380417;
    localparam int RS_B = 23;
    localparam int L    = 4;
    localparam int TW   = 8;

    typedef struct packed {
        logic [TW-1:0]     tag;
        logic [L*RS_A-1:0] r;
        logic [L*RS_A-1:0] q;
        logic [L-1:0]      ovf;
    } exp_a_t;

    typedef struct packed {
        logic [TW-1:0]     tag;
        logic [L*RS_B-1:0] r;
        logic [L*RS_B-1:0] q;
        logic [L-1:0]      ovf;
    } exp_b_t;

    logic clk;
    logic reset_n;

    logic                  zeroize, in_valid, in_ready, out_valid, out_ready;
    logic [L*2*RS_A-1:0]   in_x;
    logic [TW-1:0]         in_tag, out_tag;
    logic [L*RS_A-1:0]     out_r, out_q;
    logic [L-1:0]          out_ovf;

    logic                  zeroize_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [L*2*RS_B-1:0]   in_x_b;
    logic [TW-1:0]         in_tag_b, out_tag_b;
    logic [L*RS_B-1:0]     out_r_b, out_q_b;
    logic [L-1:0]          out_ovf_b;

    exp_a_t sb_a[$];
    exp_b_t sb_b[$];
    int     errors  = 0;
    int     checks  = 0;
    int     out_cnt = 0;

    barrett_reduction_pipe #(.PRIME(P_A), .LANES(L), .TAG_W(TW)) dut_a (
        .clk(clk), .reset_n(reset_n), .zeroize(zeroize),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_q(out_q),
        .out_ovf(out_ovf), .out_tag(out_tag)
    );

    barrett_reduction_pipe #(.PRIME(P_B), .LANES(L), .TAG_W(TW)) dut_b (
        .clk(clk), .reset_n(reset_n), .zeroize(zeroize_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_x(in_x_b), .in_tag(in_tag_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_r(out_r_b), .out_q(out_q_b),
        .out_ovf(out_ovf_b), .out_tag(out_tag_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_a_t model_a(input logic [L*2*RS_A-1:0] x, input logic [TW-1:0] tag);
        exp_a_t e;
        longint xv, qf;
        e.tag = tag;
        for (int i = 0; i < L; i++) begin
            xv = longint'(x[i*2*RS_A +: 2*RS_A]);
            qf = xv / P_A;
            e.r[i*RS_A +: RS_A] = 12'(xv % P_A);
            e.q[i*RS_A +: RS_A] = 12'(qf);
            e.ovf[i]            = (qf >= 64'd4096);
        end
        return e;
    endfunction

    function automatic exp_b_t model_b(input logic [L*2*RS_B-1:0] x, input logic [TW-1:0] tag);
        exp_b_t e;
        longint xv, qf;
        e.tag = tag;
        for (int i = 0; i < L; i++) begin
            xv = longint'(x[i*2*RS_B +: 2*RS_B]);
            qf = xv / P_B;
            e.r[i*RS_B +: RS_B] = 23'(xv % P_B);
            e.q[i*RS_B +: RS_B] = 23'(qf);
            e.ovf[i]            = (qf >= 64'd8388608);
        end
        return e;
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    logic        stall_prev;
    logic [TW+2*L*RS_A+L:0] snap;
    exp_a_t      ea;
    exp_b_t      eb;
    logic        exp_rdy;

    always @(negedge clk) begin
        if (!reset_n) begin
            sb_a.delete();
            sb_b.delete();
            stall_prev = 1'b0;
        end else begin
            exp_rdy = !zeroize && !(sb_a.size() == 3 && !out_ready);
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL in_ready: got %b want %b (held=%0d out_ready=%b)",
                         in_ready, exp_rdy, sb_a.size(), out_ready);
            end
            if (stall_prev) begin
                checks++;
                if ({out_valid, out_tag, out_r, out_q, out_ovf} !== snap) begin
                    errors++;
                    $display("FAIL hold: outputs changed while stalled, got %h want %h",
                             {out_valid, out_tag, out_r, out_q, out_ovf}, snap);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                out_cnt++;
                if (sb_a.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_a: output tag=%h with empty scoreboard", out_tag);
                end else begin
                    ea = sb_a.pop_front();
                    if ({out_tag, out_r, out_q, out_ovf} !== ea) begin
                        errors++;
                        $display("FAIL result_a: got tag=%h r=%h q=%h ovf=%b want tag=%h r=%h q=%h ovf=%b",
                                 out_tag, out_r, out_q, out_ovf, ea.tag, ea.r, ea.q, ea.ovf);
                    end
                end
            end
            stall_prev = out_valid && !out_ready && !zeroize;
            snap       = {out_valid, out_tag, out_r, out_q, out_ovf};
            if (zeroize) sb_a.delete();
            else if (in_valid && in_ready) sb_a.push_back(model_a(in_x, in_tag));

            if (out_valid_b && out_ready_b) begin
                checks++;
                if (sb_b.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_b: output tag=%h with empty scoreboard", out_tag_b);
                end else begin
                    eb = sb_b.pop_front();
                    if ({out_tag_b, out_r_b, out_q_b, out_ovf_b} !== eb) begin
                        errors++;
                        $display("FAIL result_b: got tag=%h r=%h q=%h ovf=%b want tag=%h r=%h q=%h ovf=%b",
                                 out_tag_b, out_r_b, out_q_b, out_ovf_b, eb.tag, eb.r, eb.q, eb.ovf);
                    end
                end
            end
            if (in_valid_b && in_ready_b) sb_b.push_back(model_b(in_x_b, in_tag_b));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat to instance A and hold it until accepted (bounded).
    task automatic send_a(input logic [L*2*RS_A-1:0] x, input logic [TW-1:0] tag);
        in_valid = 1'b1;
        in_x     = x;
        in_tag   = tag;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: tag=%h not accepted in 50 cycles", tag);
        in_valid = 1'b0;
    endtask

    function automatic logic [L*2*RS_A-1:0] rand_x_a();
        logic [L*2*RS_A-1:0] x;
        for (int i = 0; i < L; i++) x[i*2*RS_A +: 2*RS_A] = 24'($urandom);
        return x;
    endfunction

    function automatic logic [L*2*RS_B-1:0] rand_x_b();
        logic [L*2*RS_B-1:0] x;
        logic [63:0]         t;
        for (int i = 0; i < L; i++) begin
            t = {$urandom, $urandom};
            x[i*2*RS_B +: 2*RS_B] = t[2*RS_B-1:0];
        end
        return x;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        out_ready = 1'b0;
        send_a(rand_x_a(), 8'h11);
        send_a(rand_x_a(), 8'h22);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_r, out_q, out_ovf, out_tag} !== '0) begin
            errors++;
            $display("FAIL reset_async: outputs=%h want 0", {out_valid, out_r, out_q, out_ovf, out_tag});
        end
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        checks++;
        if ({out_valid, out_r, out_q, out_ovf, out_tag} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {out_valid, out_r, out_q, out_ovf, out_tag});
        end
        out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_output: out_valid=%b want 0 at cycle %0d", out_valid, n);
            end
        end
    endtask

    // Drive one beat from an idle pipeline and check it appears after exactly 3 edges.
    task automatic latency_beat(input logic [L*2*RS_A-1:0] x, input logic [TW-1:0] tag, input string name);
        in_valid = 1'b1;
        in_x     = x;
        in_tag   = tag;
        tick();
        in_valid = 1'b0;
        for (int n = 1; n <= 2; n++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_early: out_valid=%b want 0 after %0d edges", name, out_valid, n);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || out_tag !== tag) begin
            errors++;
            $display("FAIL %s_latency: out_valid=%b tag=%h want 1 tag=%h after 3 edges", name, out_valid, out_tag, tag);
        end
    endtask

    task automatic test_directed();
        out_ready = 1'b1;
        latency_beat({24'd11082240, 24'd3329, 24'd3328, 24'd0}, 8'h5A, "directed");
        checks++;
        if (out_r !== {12'd3328, 12'd0, 12'd3328, 12'd0}) begin
            errors++;
            $display("FAIL directed_r: got %h want %h", out_r, {12'd3328, 12'd0, 12'd3328, 12'd0});
        end
        checks++;
        if (out_q !== {12'd3328, 12'd1, 12'd0, 12'd0} || out_ovf !== 4'b0000) begin
            errors++;
            $display("FAIL directed_q: got q=%h ovf=%b want q=%h ovf=0000",
                     out_q, out_ovf, {12'd3328, 12'd1, 12'd0, 12'd0});
        end
        tick();
    endtask

    task automatic test_overflow();
        logic [11:0] r_want;
        r_want = 12'(16777215 % P_A);
        out_ready = 1'b1;
        latency_beat({24'd1000, 24'd6657, 24'd6658, 24'hFFFFFF}, 8'hC3, "overflow");
        checks++;
        if (out_q[11:0] !== 12'd943 || out_ovf[0] !== 1'b1 || out_r[11:0] !== r_want) begin
            errors++;
            $display("FAIL overflow_lane0: got r=%0d q=%0d ovf=%b want r=%0d q=943 ovf=1",
                     out_r[11:0], out_q[11:0], out_ovf[0], r_want);
        end
        checks++;
        if (out_ovf[3:1] !== 3'b000) begin
            errors++;
            $display("FAIL overflow_others: got ovf=%b want 000 in lanes 3..1", out_ovf[3:1]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int                  sent, cyc, start;
        logic [L*2*RS_A-1:0] cur_x;
        sent  = 0;
        cyc   = 0;
        start = out_cnt;
        cur_x = rand_x_a();
        while ((sent < 20 || sb_a.size() != 0) && cyc < 400) begin
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 20) begin
                in_valid = 1'b1;
                in_x     = cur_x;
                in_tag   = 8'(sent);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                sent++;
                cur_x = rand_x_a();
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_cnt - start != 20 || sb_a.size() != 0) begin
            errors++;
            $display("FAIL stream_count: emitted %0d pending %0d want 20 and 0", out_cnt - start, sb_a.size());
        end
    endtask

    task automatic test_zeroize();
        int start;
        out_ready = 1'b0;
        send_a(rand_x_a(), 8'hA1);
        send_a(rand_x_a(), 8'hA2);
        send_a(rand_x_a(), 8'hA3);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL zeroize_fill: out_valid=%b want 1 before clear", out_valid);
        end
        zeroize  = 1'b1;
        in_valid = 1'b1;
        in_x     = rand_x_a();
        in_tag   = 8'hEE;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL zeroize_in_ready: got %b want 0", in_ready);
        end
        tick();
        zeroize  = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zeroize_clear: out_valid=%b want 0", out_valid);
        end
        out_ready = 1'b1;
        start     = out_cnt;
        repeat (6) tick();
        checks++;
        if (out_cnt != start) begin
            errors++;
            $display("FAIL zeroize_leak: %0d beats emerged want 0", out_cnt - start);
        end
        latency_beat(rand_x_a(), 8'h77, "zeroize_after");
        tick();
    endtask

    task automatic test_sweep();
        out_ready   = 1'b1;
        out_ready_b = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            in_valid   = 1'b1;
            in_valid_b = 1'b1;
            in_tag     = 8'($urandom);
            in_tag_b   = 8'($urandom);
            if (n == 0) begin
                in_x   = '1;
                in_x_b = '1;
            end else if (n == 1) begin
                in_x   = '0;
                in_x_b = '0;
            end else begin
                in_x   = rand_x_a();
                in_x_b = rand_x_b();
            end
            tick();
        end
        in_valid   = 1'b0;
        in_valid_b = 1'b0;
        repeat (6) tick();
        checks++;
        if (sb_a.size() != 0 || sb_b.size() != 0) begin
            errors++;
            $display("FAIL sweep_drain: pending a=%0d b=%0d want 0", sb_a.size(), sb_b.size());
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        zeroize     = 1'b0;
        in_valid    = 1'b0;
        in_x        = '0;
        in_tag      = '0;
        out_ready   = 1'b0;
        zeroize_b   = 1'b0;
        in_valid_b  = 1'b0;
        in_x_b      = '0;
        in_tag_b    = '0;
        out_ready_b = 1'b1;
        test_reset();
        test_directed();
        test_overflow();
        test_back_to_back();
        test_zeroize();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
